// File: rtl/spi_mem_pkg.sv
// ============================================================================
// Module : spi_mem_pkg
// Brief  : Shared types and frame-length helper for the SPI-to-memory bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_mem_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        EXEC = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_e;

    // Frame = 2 command bits followed by a payload as wide as the wider field.
    function automatic int frame_len(input int aw, input int dw);
        return 2 + ((aw > dw) ? aw : dw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mem_array.sv
// ============================================================================
// Module : spi_mem_array
// Brief  : Single-clock memory, one write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_mem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Addresses are range-checked by the caller; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/spi_mem_bridge.sv
// ============================================================================
// Module : spi_mem_bridge
// Brief  : SPI-slave frame decoder driving a memory with optional auto-increment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_mem_bridge
    import spi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);

    localparam int c_F  = frame_len(ADDR_WIDTH, DATA_WIDTH);
    localparam int c_CW = $clog2(c_F + 1);
    localparam logic [c_CW-1:0]       c_LAST_BIT = c_CW'(c_F - 1);
    localparam logic [c_CW-1:0]       c_LAST_TX  = c_CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_TOP      = ADDR_WIDTH'(MEM_DEPTH - 1);

    function automatic logic [ADDR_WIDTH-1:0] inc_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a >= c_TOP) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    state_e                r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [c_F-1:0]        r_shift;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_miso;

    cmd_e                  w_cmd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_we;
    logic                  w_re;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_tx;

    assign w_cmd   = cmd_e'(r_shift[c_F-1 -: 2]);
    assign w_addr  = r_shift[ADDR_WIDTH-1:0];
    assign w_data  = r_shift[DATA_WIDTH-1:0];
    assign w_wr_ok = ({1'b0, r_wr_addr} < c_DEPTH);
    assign w_rd_ok = ({1'b0, r_rd_addr} < c_DEPTH);
    // Gated by rst_n so a reset landing on the EXEC edge drops the write.
    assign w_we    = rst_n && (r_state == EXEC) && (w_cmd == WR_DATA) && w_wr_ok;
    // rd_addr is stable while a frame is shifted in, so the word is ready at EXEC.
    assign w_re    = (r_state == RECV);
    assign w_tx    = w_rd_ok ? w_rdata : '0;

    spi_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_addr),
        .i_wdata (w_data),
        .i_re    (w_re),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_miso    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_miso <= 1'b0;
                    if (!SS_n) begin
                        r_shift <= {r_shift[c_F-2:0], MOSI};
                        r_cnt   <= c_CW'(1);
                        r_state <= RECV;
                    end
                end
                RECV: begin
                    if (SS_n) begin
                        r_state <= IDLE;
                    end else begin
                        r_shift <= {r_shift[c_F-2:0], MOSI};
                        r_cnt   <= r_cnt + c_CW'(1);
                        if (r_cnt == c_LAST_BIT) begin
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    case (w_cmd)
                        WR_ADDR: begin
                            r_wr_addr <= w_addr;
                            r_state   <= DONE;
                        end
                        WR_DATA: begin
                            if (AUTO_INC != 0) begin
                                r_wr_addr <= inc_addr(r_wr_addr);
                            end
                            r_state <= DONE;
                        end
                        RD_ADDR: begin
                            r_rd_addr <= w_addr;
                            r_state   <= DONE;
                        end
                        RD_DATA: begin
                            r_miso  <= w_tx[DATA_WIDTH-1];
                            r_tx    <= w_tx << 1;
                            r_cnt   <= '0;
                            r_state <= SEND;
                        end
                        default: r_state <= DONE;
                    endcase
                end
                SEND: begin
                    if (SS_n) begin
                        r_miso  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == c_LAST_TX) begin
                        r_miso <= 1'b0;
                        if (AUTO_INC != 0) begin
                            r_rd_addr <= inc_addr(r_rd_addr);
                        end
                        r_state <= DONE;
                    end else begin
                        r_miso <= r_tx[DATA_WIDTH-1];
                        r_tx   <= r_tx << 1;
                        r_cnt  <= r_cnt + c_CW'(1);
                    end
                end
                DONE: begin
                    r_miso <= 1'b0;
                    if (SS_n) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_miso  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign MISO = r_miso;

endmodule

`default_nettype wire

// File: tb/tb_spi_mem_bridge.sv
// ============================================================================
// Module : tb_spi_mem_bridge
// Brief  : Directed self-checking bench for spi_mem_bridge (three configurations).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_mem_bridge;
    import spi_mem_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       mosi;
    logic [2:0] ss_n;
    logic [2:0] miso;

    int errors;
    int checks;

    logic [7:0] rd;
    logic       tail;

    // dut0: defaults, dut1: MEM_DEPTH=200, dut2: AUTO_INC=0
    spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .MOSI(mosi), .SS_n(ss_n[0]), .MISO(miso[0]));
    spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .MOSI(mosi), .SS_n(ss_n[1]), .MISO(miso[1]));
    spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .MOSI(mosi), .SS_n(ss_n[2]), .MISO(miso[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Full 10-bit frame; for RD_DATA collects 8 MISO bits and the bit after them.
    task automatic frame(input int sel, input logic [1:0] cmd, input logic [7:0] pay,
                         output logic [7:0] r, output logic t);
        logic [9:0] f;
        f = {cmd, pay};
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            ss_n[sel] = 1'b0;
            mosi      = f[i];
        end
        @(negedge clk);
        mosi = 1'b0;
        r = '0;
        t = 1'b0;
        if (cmd == 2'b11) begin
            for (int i = 7; i >= 0; i--) begin
                @(negedge clk);
                r[i] = miso[sel];
            end
            @(negedge clk);
            t = miso[sel];
        end else begin
            @(negedge clk);
        end
        ss_n[sel] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        if (miso !== 3'b000) begin
            errors++;
            $display("FAIL reset_miso: got %b expected 000", miso);
        end
        checks++;
        if (dut0.r_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut0.r_state, IDLE);
        end
        checks++;
    endtask

    task automatic test_basic_rw();
        frame(0, 2'b00, 8'h10, rd, tail);
        frame(0, 2'b01, 8'hA5, rd, tail);
        frame(0, 2'b10, 8'h10, rd, tail);
        frame(0, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'hA5) begin
            errors++;
            $display("FAIL basic_read: got %h expected a5", rd);
        end
        checks++;
        if (tail !== 1'b0) begin
            errors++;
            $display("FAIL basic_tail: got %b expected 0", tail);
        end
        checks++;
    endtask

    task automatic test_auto_inc();
        frame(0, 2'b01, 8'h3C, rd, tail);
        frame(0, 2'b01, 8'h81, rd, tail);
        frame(0, 2'b10, 8'h11, rd, tail);
        frame(0, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h3C) begin
            errors++;
            $display("FAIL inc_read_11: got %h expected 3c", rd);
        end
        checks++;
        frame(0, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h81) begin
            errors++;
            $display("FAIL inc_read_12: got %h expected 81", rd);
        end
        checks++;
    endtask

    task automatic test_depth_wrap();
        frame(1, 2'b00, 8'd199, rd, tail);
        frame(1, 2'b01, 8'h11, rd, tail);
        frame(1, 2'b01, 8'h22, rd, tail);
        frame(1, 2'b00, 8'hF0, rd, tail);
        frame(1, 2'b01, 8'h77, rd, tail);
        frame(1, 2'b10, 8'd199, rd, tail);
        frame(1, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h11) begin
            errors++;
            $display("FAIL wrap_read_199: got %h expected 11", rd);
        end
        checks++;
        frame(1, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h22) begin
            errors++;
            $display("FAIL wrap_read_0: got %h expected 22", rd);
        end
        checks++;
        frame(1, 2'b10, 8'hF0, rd, tail);
        frame(1, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL oob_read: got %h expected 00", rd);
        end
        checks++;
        // wr_addr wrapped from 0xF0 to 0 after the dropped write
        frame(1, 2'b01, 8'h33, rd, tail);
        frame(1, 2'b10, 8'h00, rd, tail);
        frame(1, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h33) begin
            errors++;
            $display("FAIL oob_wrap_write: got %h expected 33", rd);
        end
        checks++;
    endtask

    task automatic test_abort();
        logic [9:0] f;
        frame(0, 2'b00, 8'h30, rd, tail);
        frame(0, 2'b01, 8'h99, rd, tail);
        frame(0, 2'b00, 8'h30, rd, tail);
        f = {2'b01, 8'hEE};
        for (int i = 9; i >= 4; i--) begin
            @(negedge clk);
            ss_n[0] = 1'b0;
            mosi    = f[i];
        end
        @(negedge clk);
        ss_n[0] = 1'b1;
        mosi    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        frame(0, 2'b10, 8'h30, rd, tail);
        frame(0, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h99) begin
            errors++;
            $display("FAIL abort_mem_kept: got %h expected 99", rd);
        end
        checks++;
        frame(0, 2'b01, 8'h44, rd, tail);
        frame(0, 2'b10, 8'h30, rd, tail);
        frame(0, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h44) begin
            errors++;
            $display("FAIL abort_next_frame: got %h expected 44", rd);
        end
        checks++;
    endtask

    task automatic test_no_inc();
        frame(2, 2'b00, 8'h05, rd, tail);
        frame(2, 2'b01, 8'h5A, rd, tail);
        frame(2, 2'b10, 8'h05, rd, tail);
        frame(2, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h5A) begin
            errors++;
            $display("FAIL noinc_read1: got %h expected 5a", rd);
        end
        checks++;
        frame(2, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h5A) begin
            errors++;
            $display("FAIL noinc_read2: got %h expected 5a", rd);
        end
        checks++;
        if (dut2.r_rd_addr !== 8'h05) begin
            errors++;
            $display("FAIL noinc_rd_addr: got %h expected 05", dut2.r_rd_addr);
        end
        checks++;
    endtask

    task automatic test_reset_in_send();
        logic [9:0] f;
        logic [2:0] got;
        frame(0, 2'b00, 8'h40, rd, tail);
        frame(0, 2'b01, 8'h5C, rd, tail);
        frame(0, 2'b10, 8'h40, rd, tail);
        f = {2'b11, 8'h00};
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            ss_n[0] = 1'b0;
            mosi    = f[i];
        end
        @(negedge clk);
        mosi = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            got[i] = miso[0];
        end
        if (got !== 3'b010) begin
            errors++;
            $display("FAIL rst_send_prefix: got %b expected 010", got);
        end
        checks++;
        rst_n = 1'b0;
        @(negedge clk);
        if (miso[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_send_miso: got %b expected 0", miso[0]);
        end
        checks++;
        if (dut0.r_state !== IDLE) begin
            errors++;
            $display("FAIL rst_send_state: got %0d expected %0d", dut0.r_state, IDLE);
        end
        checks++;
        if (dut0.r_wr_addr !== 8'h00 || dut0.r_rd_addr !== 8'h00) begin
            errors++;
            $display("FAIL rst_send_addrs: got wr=%h rd=%h expected 00/00",
                     dut0.r_wr_addr, dut0.r_rd_addr);
        end
        checks++;
        rst_n   = 1'b1;
        ss_n[0] = 1'b1;
        @(negedge clk);
        frame(0, 2'b10, 8'h40, rd, tail);
        frame(0, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h5C) begin
            errors++;
            $display("FAIL rst_mem_kept: got %h expected 5c", rd);
        end
        checks++;
        // wr_addr is back at 0 after reset
        frame(0, 2'b01, 8'h9D, rd, tail);
        frame(0, 2'b10, 8'h00, rd, tail);
        frame(0, 2'b11, 8'h00, rd, tail);
        if (rd !== 8'h9D) begin
            errors++;
            $display("FAIL rst_wr_addr_zero: got %h expected 9d", rd);
        end
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        mosi   = 1'b0;
        ss_n   = 3'b111;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic_rw();
        test_auto_inc();
        test_depth_wrap();
        test_abort();
        test_no_inc();
        test_reset_in_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
